// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multicycle control FSM and the MIPS datapath.
// master = controller side, slave = datapath side.
interface mc_ctrl_if #(
    parameter int unsigned IRWIDTH_N = 32
);
    logic [5:0]           op;
    logic [5:0]           funct;
    logic                 zero;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 ir_write;
    logic                 reg_write;
    logic                 mem_write;
    logic [1:0]           eop;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic [2:0]           alu_op;
    logic [1:0]           pc_src;
    logic [1:0]           reg_dst;
    logic [1:0]           wd_sel;
    logic                 instr_done;
    logic                 illegal;
    logic [IRWIDTH_N-1:0] instr_cnt;

    modport master (
        input  op, funct, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_write, eop, alu_src_a, alu_src_b,
               alu_op, pc_src, reg_dst, wd_sel, instr_done, illegal, instr_cnt
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_write, eop, alu_src_a, alu_src_b,
               alu_op, pc_src, reg_dst, wd_sel, instr_done, illegal, instr_cnt
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: sequences PC/IR/regfile/memory/ALU/extender over 2-5 cycles.
// Optional macro MC_STALL_EN: FETCH, MEM_RD and MEM_WR hold until mem_ready.
module mc_ctrl #(
    parameter int unsigned IRWIDTH_N = 32
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master io_dp
);
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_PASS = 3'b011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXE_R   = 4'd2,
        S_EXE_I   = 4'd3,
        S_ALU_WB  = 4'd4,
        S_MEM_ADR = 4'd5,
        S_MEM_RD  = 4'd6,
        S_MEM_WB  = 4'd7,
        S_MEM_WR  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10
    } state_t;

    state_t               r_state;
    logic [IRWIDTH_N-1:0] r_instr_cnt;
    logic                 w_mem_ok;

`ifdef MC_STALL_EN
    assign w_mem_ok = io_dp.mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = io_dp.mem_ready;
    assign w_mem_ok           = 1'b1;
`endif

    logic w_is_rarith, w_is_jr, w_is_subu, w_is_imm, w_is_lui, w_is_mem, w_is_lw;
    logic w_is_beq, w_is_jump, w_is_jal, w_legal;

    assign w_is_subu   = (io_dp.op == OP_R) && (io_dp.funct == FN_SUBU);
    assign w_is_rarith = (io_dp.op == OP_R) && ((io_dp.funct == FN_ADDU) || w_is_subu);
    assign w_is_jr     = (io_dp.op == OP_R) && (io_dp.funct == FN_JR);
    assign w_is_lui    = (io_dp.op == OP_LUI);
    assign w_is_imm    = (io_dp.op == OP_ORI) || w_is_lui;
    assign w_is_lw     = (io_dp.op == OP_LW);
    assign w_is_mem    = w_is_lw || (io_dp.op == OP_SW);
    assign w_is_beq    = (io_dp.op == OP_BEQ);
    assign w_is_jal    = (io_dp.op == OP_JAL);
    assign w_is_jump   = (io_dp.op == OP_J) || w_is_jal || w_is_jr;
    assign w_legal     = w_is_rarith || w_is_imm || w_is_mem || w_is_beq || w_is_jump;

    // State sequencing; terminal states and illegal encodings fall back to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:   if (w_mem_ok) r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_is_rarith)    r_state <= S_EXE_R;
                    else if (w_is_imm)  r_state <= S_EXE_I;
                    else if (w_is_mem)  r_state <= S_MEM_ADR;
                    else if (w_is_beq)  r_state <= S_BRANCH;
                    else if (w_is_jump) r_state <= S_JUMP;
                    else                r_state <= S_FETCH;
                end
                S_EXE_R:   r_state <= S_ALU_WB;
                S_EXE_I:   r_state <= S_ALU_WB;
                S_MEM_ADR: r_state <= w_is_lw ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:  if (w_mem_ok) r_state <= S_MEM_WB;
                S_MEM_WR:  if (w_mem_ok) r_state <= S_FETCH;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    logic       w_pc_write, w_ir_write, w_reg_write, w_mem_write, w_alu_src_a;
    logic       w_instr_done, w_illegal;
    logic [1:0] w_eop, w_alu_src_b, w_pc_src, w_reg_dst, w_wd_sel;
    logic [2:0] w_alu_op;

    // Datapath controls decoded from state; reset forces every enable low immediately.
    always_comb begin
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_eop        = 2'b00;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = ALU_ADD;
        w_pc_src     = 2'b00;
        w_reg_dst    = 2'b00;
        w_wd_sel     = 2'b00;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write  = w_mem_ok;
                w_pc_write  = w_mem_ok;
                w_alu_src_b = 2'b01;
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                w_eop       = 2'b11;
                w_illegal   = ~w_legal;
            end
            S_EXE_R: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = w_is_subu ? ALU_SUB : ALU_ADD;
            end
            S_EXE_I: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_eop       = w_is_lui ? 2'b10 : 2'b01;
                w_alu_op    = w_is_lui ? ALU_PASS : ALU_OR;
            end
            S_ALU_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = (io_dp.op == OP_R) ? 2'b01 : 2'b00;
                w_instr_done = 1'b1;
            end
            S_MEM_ADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_wd_sel     = 2'b01;
                w_instr_done = 1'b1;
            end
            S_MEM_WR: begin
                w_mem_write  = w_mem_ok;
                w_instr_done = w_mem_ok;
            end
            S_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = ALU_SUB;
                w_pc_write   = io_dp.zero;
                w_pc_src     = 2'b01;
                w_instr_done = 1'b1;
            end
            S_JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_src     = w_is_jr ? 2'b11 : 2'b10;
                w_reg_write  = w_is_jal;
                w_reg_dst    = w_is_jal ? 2'b10 : 2'b00;
                w_wd_sel     = w_is_jal ? 2'b10 : 2'b00;
                w_instr_done = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            w_pc_write   = 1'b0;
            w_ir_write   = 1'b0;
            w_reg_write  = 1'b0;
            w_mem_write  = 1'b0;
            w_instr_done = 1'b0;
            w_illegal    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             r_instr_cnt <= '0;
        else if (w_instr_done) r_instr_cnt <= r_instr_cnt + IRWIDTH_N'(1);
    end

    assign io_dp.pc_write   = w_pc_write;
    assign io_dp.ir_write   = w_ir_write;
    assign io_dp.reg_write  = w_reg_write;
    assign io_dp.mem_write  = w_mem_write;
    assign io_dp.eop        = w_eop;
    assign io_dp.alu_src_a  = w_alu_src_a;
    assign io_dp.alu_src_b  = w_alu_src_b;
    assign io_dp.alu_op     = w_alu_op;
    assign io_dp.pc_src     = w_pc_src;
    assign io_dp.reg_dst    = w_reg_dst;
    assign io_dp.wd_sel     = w_wd_sel;
    assign io_dp.instr_done = w_instr_done;
    assign io_dp.illegal    = w_illegal;
    assign io_dp.instr_cnt  = r_instr_cnt;
endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected control vectors queued per instruction.
module tb_mc_ctrl;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] eop;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       done;
        logic       illegal;
    } vec_t;

    typedef struct packed {
        vec_t v;
        logic mr;
    } ent_t;

    logic    clk = 1'b0;
    logic    reset;
    ent_t    sb[$];
    int      n_vec = 0;
    int      n_err = 0;
    logic [CW-1:0] exp_cnt = '0;

    mc_ctrl_if #(.IRWIDTH_N(CW)) dp ();
    mc_ctrl #(.IRWIDTH_N(CW)) u_dut (.clk(clk), .reset(reset), .io_dp(dp));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic vec_t observe();
        vec_t v;
        v.pc_write  = dp.pc_write;   v.ir_write  = dp.ir_write;
        v.reg_write = dp.reg_write;  v.mem_write = dp.mem_write;
        v.eop       = dp.eop;        v.alu_src_a = dp.alu_src_a;
        v.alu_src_b = dp.alu_src_b;  v.alu_op    = dp.alu_op;
        v.pc_src    = dp.pc_src;     v.reg_dst   = dp.reg_dst;
        v.wd_sel    = dp.wd_sel;     v.done      = dp.instr_done;
        v.illegal   = dp.illegal;
        return v;
    endfunction

    function automatic logic [5:0] enables(input vec_t v);
        return {v.pc_write, v.ir_write, v.reg_write, v.mem_write, v.done, v.illegal};
    endfunction

    // mem_ready is noise without stalls; with stalls it stays high unless a test says otherwise
    function automatic logic mr_bit();
`ifdef MC_STALL_EN
        return 1'b1;
`else
        return 1'($urandom_range(0, 1));
`endif
    endfunction

    task automatic push(input vec_t v, input logic mr);
        ent_t e;
        e.v  = v;
        e.mr = mr;
        sb.push_back(e);
    endtask

    task automatic push_fetch();
        vec_t v = '0;
        v.pc_write = 1'b1; v.ir_write = 1'b1; v.alu_src_b = 2'b01;
        push(v, mr_bit());
    endtask

    task automatic push_decode(input logic ill);
        vec_t v = '0;
        v.alu_src_b = 2'b11; v.eop = 2'b11; v.illegal = ill;
        push(v, mr_bit());
    endtask

    task automatic push_mem_adr();
        vec_t v = '0;
        v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.eop = 2'b00; v.alu_op = 3'b000;
        push(v, mr_bit());
    endtask

    // Expected cycle-by-cycle controls for one instruction with no memory stalls.
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              output logic legal);
        vec_t v = '0;
        legal = 1'b1;
        push_fetch();
        if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
            push_decode(1'b0);
            v.alu_src_a = 1'b1; v.alu_op = (fn == 6'h23) ? 3'b001 : 3'b000;
            push(v, mr_bit());
            v = '0; v.reg_write = 1'b1; v.reg_dst = 2'b01; v.done = 1'b1;
            push(v, mr_bit());
        end else if (op == 6'h0D || op == 6'h0F) begin
            push_decode(1'b0);
            v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
            v.eop    = (op == 6'h0F) ? 2'b10 : 2'b01;
            v.alu_op = (op == 6'h0F) ? 3'b011 : 3'b010;
            push(v, mr_bit());
            v = '0; v.reg_write = 1'b1; v.reg_dst = 2'b00; v.done = 1'b1;
            push(v, mr_bit());
        end else if (op == 6'h23) begin
            push_decode(1'b0);
            push_mem_adr();
            push('0, mr_bit());
            v.reg_write = 1'b1; v.wd_sel = 2'b01; v.done = 1'b1;
            push(v, mr_bit());
        end else if (op == 6'h2B) begin
            push_decode(1'b0);
            push_mem_adr();
            v.mem_write = 1'b1; v.done = 1'b1;
            push(v, mr_bit());
        end else if (op == 6'h04) begin
            push_decode(1'b0);
            v.alu_src_a = 1'b1; v.alu_op = 3'b001; v.pc_write = z; v.pc_src = 2'b01;
            v.done = 1'b1;
            push(v, mr_bit());
        end else if (op == 6'h02 || op == 6'h03 || (op == 6'h00 && fn == 6'h08)) begin
            push_decode(1'b0);
            v.pc_write = 1'b1; v.done = 1'b1;
            v.pc_src = (op == 6'h00) ? 2'b11 : 2'b10;
            if (op == 6'h03) begin
                v.reg_write = 1'b1; v.reg_dst = 2'b10; v.wd_sel = 2'b10;
            end
            push(v, mr_bit());
        end else begin
            legal = 1'b0;
            push_decode(1'b1);
        end
    endtask

    // Called at a falling edge: drive mem_ready, sample, compare, advance to next falling edge.
    task automatic step(input string name, input int idx);
        ent_t e = sb.pop_front();
        dp.mem_ready = e.mr;
        #1;
        check_eq($sformatf("%s.c%0d", name, idx), 32'(observe()), 32'(e.v));
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int idx = 0;
        while (sb.size() > 0) begin
            step(name, idx);
            idx++;
        end
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z);
        logic legal;
        dp.op = op; dp.funct = fn; dp.zero = z;
        push_instr(op, fn, z, legal);
        drain(name);
        if (legal) exp_cnt = exp_cnt + CW'(1);
        check_eq({name, ".cnt"}, 32'(dp.instr_cnt), 32'(exp_cnt));
    endtask

    logic [5:0] tbl_op [10] = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h00};
    logic [5:0] tbl_fn [10] = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08};

    initial begin
        ent_t e;
        reset = 1'b1;
        dp.op = 6'h00; dp.funct = 6'h21; dp.zero = 1'b0; dp.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset.en", 32'(enables(observe())), 32'(0));
        check_eq("reset.cnt", 32'(dp.instr_cnt), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        run_instr("addu", 6'h00, 6'h21, 1'b0);
        run_instr("subu", 6'h00, 6'h23, 1'b0);
        run_instr("lui", 6'h0F, 6'h00, 1'b0);
        run_instr("ori", 6'h0D, 6'h15, 1'b1);
        run_instr("beq_t", 6'h04, 6'h00, 1'b1);
        run_instr("beq_nt", 6'h04, 6'h00, 1'b0);
        run_instr("lw", 6'h23, 6'h00, 1'b0);
        run_instr("sw", 6'h2B, 6'h00, 1'b0);
        run_instr("j", 6'h02, 6'h00, 1'b0);
        run_instr("jal", 6'h03, 6'h00, 1'b0);
        run_instr("jr", 6'h00, 6'h08, 1'b0);
        run_instr("ill_op", 6'h3F, 6'h00, 1'b0);
        run_instr("ill_fn", 6'h00, 6'h3F, 1'b0);

        // Reset landing in MEM_RD of a lw
        dp.op = 6'h23; dp.funct = 6'h00;
        begin
            logic legal;
            push_instr(6'h23, 6'h00, 1'b0, legal);
        end
        for (int i = 0; i < 3; i++) step("rst_lw", i);
        e = sb.pop_front();
        dp.mem_ready = e.mr;
        #1;
        check_eq("rst_lw.c3", 32'(observe()), 32'(e.v));
        reset = 1'b1;
        #1;
        check_eq("rst_lw.en", 32'(enables(observe())), 32'(0));
        check_eq("rst_lw.cnt", 32'(dp.instr_cnt), 32'(0));
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
        reset = 1'b0;

        // Enough retirements to wrap the narrow counter
        for (int i = 0; i < 20; i++) begin
            int k = $urandom_range(0, 9);
            run_instr($sformatf("mix%0d", i), tbl_op[k], tbl_fn[k], 1'($urandom_range(0, 1)));
        end

`ifdef MC_STALL_EN
        // sw with mem_ready low for three MEM_WR cycles
        begin
            vec_t v = '0;
            dp.op = 6'h2B; dp.funct = 6'h00;
            push_fetch();
            push_decode(1'b0);
            push_mem_adr();
            for (int i = 0; i < 3; i++) push('0, 1'b0);
            v.mem_write = 1'b1; v.done = 1'b1;
            push(v, 1'b1);
            drain("sw_stall");
            exp_cnt = exp_cnt + CW'(1);
            check_eq("sw_stall.cnt", 32'(dp.instr_cnt), 32'(exp_cnt));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control FSM for the single-issue MIPS datapath. Decodes opcode/funct from the instruction register and sequences PC, IR, register file, memory, ALU and the immediate extender (including its 2-bit `EOp` select) over 2–5 cycles per instruction. It sits beside the datapath and drives every write enable and mux select in it.

## Interface
- `IRWIDTH_N`, default 32: width of the retired-instruction counter.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; state goes to `S_FETCH`.
- `op` in 6: IR[31:26], stable from the cycle after `S_FETCH`.
- `funct` in 6: IR[5:0].
- `zero` in 1: combinational ALU zero flag.
- `mem_ready` in 1: memory done (used only with `MC_STALL_EN`).
- `pc_write` out 1; `ir_write` out 1; `reg_write` out 1; `mem_write` out 1.
- `eop` out 2: extender select. 00 sign, 01 zero, 10 upper (lui), 11 sign<<2.
- `alu_src_a` out 1: 0 PC, 1 rs.
- `alu_src_b` out 2: 00 rt, 01 const 4, 10/11 ext.
- `alu_op` out 3: 000 add, 001 sub, 010 or, 011 pass B.
- `pc_src` out 2: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
- `reg_dst` out 2: 00 rt, 01 rd, 10 $31.
- `wd_sel` out 2: 00 ALUOut, 01 MDR, 10 PC.
- `instr_done` out 1: high in the final cycle of each instruction.
- `illegal` out 1: high in `S_DECODE` for an unsupported encoding.
- `instr_cnt` out `IRWIDTH_N`: retired-instruction count.

## Operation
- Supported instructions: addu, subu (op 0, funct 21/23), jr (op 0, funct 08), ori 0D, lui 0F, lw 23, sw 2B, beq 04, j 02, jal 03.
- States use a 4-bit encoding:
  - `S_FETCH`=0: ir_write, pc_write, src_a=0, src_b=01, add, pc_src=00.
  - `S_DECODE`=1: src_a=0, src_b=11, eop=11, add; this precomputes the branch target into ALUOut.
  - `S_EXE_R`=2: src_a=1, src_b=00, add/sub.
  - `S_EXE_I`=3: src_a=1, src_b=10. ori: eop=01, or. lui: eop=10, pass B.
  - `S_ALU_WB`=4: reg_write, wd_sel=00, reg_dst=01 for R-type, 00 for I-type.
  - `S_MEM_ADR`=5: src_a=1, src_b=10, eop=00, add.
  - `S_MEM_RD`=6: read cycle only.
  - `S_MEM_WB`=7: reg_write, wd_sel=01, reg_dst=00.
  - `S_MEM_WR`=8: mem_write.
  - `S_BRANCH`=9: src_a=1, src_b=00, sub, pc_write=zero, pc_src=01.
  - `S_JUMP`=10: pc_write. j: pc_src=10. jal: pc_src=10, reg_write, reg_dst=10, wd_sel=10. jr: pc_src=11.
- Transitions from `S_DECODE`:
  - R-arith → `S_EXE_R` → `S_ALU_WB`.
  - ori/lui → `S_EXE_I` → `S_ALU_WB`.
  - lw → `S_MEM_ADR` → `S_MEM_RD` → `S_MEM_WB`.
  - sw → `S_MEM_ADR` → `S_MEM_WR`.
  - beq → `S_BRANCH`.
  - j/jal/jr → `S_JUMP`.
  - Illegal encoding → `S_FETCH`, no side effects.
- All terminal states return to `S_FETCH`.
- Every output not listed for a state is 0. Outputs are combinational from the state plus `op`/`funct`/`zero`.
- `instr_cnt` increments by 1 on each cycle where `instr_done`=1. It wraps modulo 2^`IRWIDTH_N`. Illegal instructions are not counted (`instr_done`=0 for them).

## Timing
- Reset:
  - While `reset`=1, all enables, `instr_done` and `illegal` are 0 and `instr_cnt`=0.
  - State is `S_FETCH` on the first edge after release.
  - `reset` mid-instruction aborts it with no further writes.
- Cycles per instruction (no stall): R/ori/lui 4, lw 5, sw 4, beq 3, j/jal/jr 3, illegal 2.
- The `zero` sample for beq is combinational within `S_BRANCH`. No extra cycle is added.
- `eop` is valid in every cycle that uses it. Elsewhere it is 00.

## Configuration
- `MC_STALL_EN` defined: `S_FETCH`, `S_MEM_RD` and `S_MEM_WR` hold while `mem_ready`=0.
  - During a hold, `pc_write`, `ir_write` and `mem_write` are asserted only in the cycle with `mem_ready`=1.
  - The state advances on that cycle.
- `MC_STALL_EN` undefined: `mem_ready` is ignored and each of these states lasts exactly 1 cycle.

## Test plan
- Reset release, then addu (op 00, funct 21): states 0→1→2→4→0. `reg_write`=1 and `reg_dst`=01 in cycle 4. `instr_cnt`=1 after that cycle.
- lui (0F): `eop`=10 and `alu_op`=011 in `S_EXE_I`. ori: `eop`=01, `alu_op`=010.
- beq with `zero`=1 → `pc_write`=1, `pc_src`=01 in cycle 3. Same with `zero`=0 → `pc_write`=0. Both take 3 cycles.
- lw: 5 cycles, `eop`=00 in `S_MEM_ADR`, `wd_sel`=01 in the last cycle. jal: `reg_dst`=10, `wd_sel`=10, `pc_src`=10 in cycle 3.
- op 3F → `illegal`=1 in `S_DECODE`, back to `S_FETCH`, `instr_cnt` unchanged. `reset` asserted in `S_MEM_RD` → all enables 0 at once.
- With `MC_STALL_EN`: `mem_ready` low for 3 cycles in `S_MEM_WR` → `mem_write`=0 for 3 cycles, then 1 for one cycle; sw takes 7 cycles.
